kbd_matrix_arbiter: RTL and testbench

- Owns the 10-row PET keyboard matrix cache and shares it between two requesters.
  - Host (Pi) row updates at $E800-$E809.
  - CPU PIA1 port A (row select) writes and port B (column) reads.
- Fully synchronous replacement for edge-triggered matrix/row logic.
- CPU accesses have fixed priority; host writes are buffered in a 2-entry FIFO and drained into idle cycles.
- Sits between the host bus bridge and the PIA1 read mux.

---
 rtl/kbd_matrix_arbiter_if.sv | 28 ++
 rtl/kbd_matrix_arbiter.sv | 139 +++++++++++++
 tb/tb_kbd_matrix_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_matrix_arbiter_if.sv
// Host-write and CPU PIA1 bus bundle for the keyboard matrix arbiter.
// The master side is the bridge/CPU side; the slave side is the arbiter.
interface kbd_matrix_arbiter_if;
  logic [15:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_wr_req;
  logic        pi_wr_ack;
  logic        cpu_strobe;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data_in;
  logic        bus_rw_b;
  logic        pia1_enabled_in;
  logic [7:0]  kbd_data_out;
  logic        kbd_enable;
  logic [1:0]  fifo_level;

  modport master (
    output pi_addr, pi_data, pi_wr_req, cpu_strobe, bus_addr, bus_data_in,
           bus_rw_b, pia1_enabled_in,
    input  pi_wr_ack, kbd_data_out, kbd_enable, fifo_level
  );

  modport slave (
    input  pi_addr, pi_data, pi_wr_req, cpu_strobe, bus_addr, bus_data_in,
           bus_rw_b, pia1_enabled_in,
    output pi_wr_ack, kbd_data_out, kbd_enable, fifo_level
  );
endinterface

// File: rtl/kbd_matrix_arbiter.sv
// PET keyboard matrix cache shared between host row writes (buffered in a
// 2-entry FIFO) and CPU PIA1 row-select/column-read accesses.
module kbd_matrix_arbiter #(
  parameter int          ROWS      = 10,
  parameter logic [15:0] BASE_ADDR = 16'hE800
) (
  input logic                 clk,
  input logic                 reset,
  kbd_matrix_arbiter_if.slave kif
);

  typedef enum logic [0:0] {
    HOST_IDLE   = 1'b0,
    HOST_ACCEPT = 1'b1
  } host_state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [7:0] data;
  } entry_t;

  localparam logic [15:0] ROWS_16 = 16'(ROWS);
  localparam logic [4:0]  ROWS_5  = 5'(ROWS);

  logic [7:0]  matrix_r [ROWS];
  entry_t      fifo_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  level_r;
  host_state_t host_state_r;
  logic        ack_r;
  logic [3:0]  current_row_r;
  logic [7:0]  kbd_data_r;
  logic        kbd_enable_r;

  logic [15:0] offset_s;
  logic        in_range_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic        port_a_wr_s;
  logic        port_b_rd_s;
  logic [7:0]  row_value_s;
  logic        unused_hi_s;

  // Host acceptance, drain and CPU access decode.
  always_comb begin
    offset_s    = kif.pi_addr - BASE_ADDR;
    in_range_s  = (offset_s < ROWS_16);
    accept_s    = (host_state_r == HOST_IDLE) && kif.pi_wr_req && (level_r != 2'd2);
    push_s      = accept_s && in_range_s;
    pop_s       = !kif.cpu_strobe && (level_r != 2'd0);
    port_a_wr_s = kif.cpu_strobe && kif.pia1_enabled_in &&
                  (kif.bus_addr == 2'd0) && !kif.bus_rw_b;
    port_b_rd_s = kif.cpu_strobe && kif.pia1_enabled_in &&
                  (kif.bus_addr == 2'd2) && kif.bus_rw_b;
    // Rows past the matrix are legal selects and read as no keys down.
    if ({1'b0, current_row_r} < ROWS_5) begin
      row_value_s = matrix_r[current_row_r];
    end else begin
      row_value_s = 8'hFF;
    end
    unused_hi_s = ^kif.bus_data_in[7:4];
  end

  // Host handshake FSM, write FIFO and matrix commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        matrix_r[i] <= 8'hFF;
      end
      fifo_r[0]    <= '0;
      fifo_r[1]    <= '0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      level_r      <= 2'd0;
      host_state_r <= HOST_IDLE;
      ack_r        <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= '{row: offset_s[3:0], data: kif.pi_data};
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        matrix_r[fifo_r[rd_ptr_r].row] <= fifo_r[rd_ptr_r].data;
        rd_ptr_r                       <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 2'd1;
        2'b01:   level_r <= level_r - 2'd1;
        default: level_r <= level_r;
      endcase
      // A held request is only taken once; the host must drop it first.
      case (host_state_r)
        HOST_IDLE: begin
          ack_r <= accept_s;
          if (accept_s) begin
            host_state_r <= HOST_ACCEPT;
          end
        end
        HOST_ACCEPT: begin
          ack_r <= 1'b0;
          if (!kif.pi_wr_req) begin
            host_state_r <= HOST_IDLE;
          end
        end
        default: begin
          ack_r        <= 1'b0;
          host_state_r <= HOST_IDLE;
        end
      endcase
    end
  end

  // CPU row select and column capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_row_r <= 4'd0;
      kbd_data_r    <= 8'hFF;
      kbd_enable_r  <= 1'b0;
    end else begin
      if (port_a_wr_s) begin
        current_row_r <= kif.bus_data_in[3:0];
      end
      if (port_b_rd_s) begin
        kbd_data_r   <= row_value_s;
        kbd_enable_r <= (row_value_s != 8'hFF);
      end else if (kif.cpu_strobe) begin
        kbd_enable_r <= 1'b0;
      end
    end
  end

  assign kif.pi_wr_ack    = ack_r;
  assign kif.kbd_data_out = kbd_data_r;
  assign kif.kbd_enable   = kbd_enable_r;
  assign kif.fifo_level   = level_r;

endmodule

// File: tb/tb_kbd_matrix_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for the FIFO
// corner cases, and random traffic against a queue-based reference model.
module tb_kbd_matrix_arbiter;
  localparam int          ROWS = 10;
  localparam logic [15:0] BASE = 16'hE800;

  logic clk;
  logic reset;
  kbd_matrix_arbiter_if k();

  kbd_matrix_arbiter #(.ROWS(ROWS), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (k)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       rst, stb, pe;
    logic [1:0] ba;
    logic       rw;
    logic [7:0] bd;
    logic       req;
    logic [15:0] pa;
    logic [7:0] pd;
    logic       ack;
    logic [7:0] kout;
    logic       ken;
    logic [1:0] lvl;
  } vec_t;

  typedef struct packed {
    logic [3:0] row;
    logic [7:0] data;
  } ent_t;

  // Reference model state: matrix bytes, FIFO as a queue, host busy flag.
  logic [7:0] m_mat [16];
  ent_t       m_q [$];
  bit         m_busy;
  logic [3:0] m_row;
  logic [7:0] m_kout;
  bit         m_ken;
  bit         m_ack;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int   lvl0;
    int   off;
    ent_t e;
    if (reset) begin
      foreach (m_mat[i]) m_mat[i] = 8'hFF;
      m_q.delete();
      m_busy = 0; m_row = 4'd0; m_kout = 8'hFF; m_ken = 0; m_ack = 0;
      return;
    end
    lvl0  = m_q.size();
    off   = int'(k.pi_addr) - int'(BASE);
    m_ack = 0;
    if (k.cpu_strobe) begin
      if (k.pia1_enabled_in && k.bus_addr == 2'd2 && k.bus_rw_b) begin
        m_kout = (int'(m_row) < ROWS) ? m_mat[m_row] : 8'hFF;
        m_ken  = (m_kout != 8'hFF);
      end else begin
        m_ken = 0;
      end
      if (k.pia1_enabled_in && k.bus_addr == 2'd0 && !k.bus_rw_b) m_row = k.bus_data_in[3:0];
    end else if (lvl0 > 0) begin
      e = m_q.pop_front();
      m_mat[e.row] = e.data;
    end
    if (m_busy) begin
      m_busy = k.pi_wr_req;
    end else if (k.pi_wr_req && lvl0 < 2) begin
      m_ack  = 1;
      m_busy = 1;
      if (off >= 0 && off < ROWS) begin
        e.row = 4'(off); e.data = k.pi_data;
        m_q.push_back(e);
      end
    end
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_ack",  16'(k.pi_wr_ack),    16'(m_ack));
    chk("model_kout", 16'(k.kbd_data_out), 16'(m_kout));
    chk("model_ken",  16'(k.kbd_enable),   16'(m_ken));
    chk("model_lvl",  16'(k.fifo_level),   16'(m_q.size()));
  endtask

  task automatic cpu(input logic stb, input logic [1:0] ba, input logic rw, input logic [7:0] bd);
    k.cpu_strobe = stb; k.pia1_enabled_in = 1'b1;
    k.bus_addr = ba; k.bus_rw_b = rw; k.bus_data_in = bd;
  endtask

  task automatic host(input logic req, input logic [15:0] pa, input logic [7:0] pd);
    k.pi_wr_req = req; k.pi_addr = pa; k.pi_data = pd;
  endtask

  task automatic read_row(input string name, input logic [7:0] row, input logic [7:0] kout, input logic ken);
    cpu(1'b1, 2'd0, 1'b0, row); cycle();
    cpu(1'b1, 2'd2, 1'b1, 8'h00); cycle();
    chk({name, "_kout"}, 16'(k.kbd_data_out), 16'(kout));
    chk({name, "_ken"},  16'(k.kbd_enable),   16'(ken));
    cpu(1'b0, 2'd0, 1'b1, 8'h00);
  endtask

  function automatic vec_t mk(logic rst, logic stb, logic pe, logic [1:0] ba, logic rw,
                              logic [7:0] bd, logic req, logic [15:0] pa, logic [7:0] pd,
                              logic ack, logic [7:0] kout, logic ken, logic [1:0] lvl);
    return '{rst, stb, pe, ba, rw, bd, req, pa, pd, ack, kout, ken, lvl};
  endfunction

  vec_t tbl [$];
  int   acks;
  int   maxl;
  bit   just_acked;

  initial begin
    reset = 1'b1;
    host(1'b0, 16'h0000, 8'h00);
    cpu(1'b0, 2'd0, 1'b1, 8'h00);

    //           rst stb pe ba rw bd     req pa        pd     ack kout   ken lvl
    tbl.push_back(mk(1, 0, 1, 0, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h03, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 1, 16'hE803, 8'hFB, 1, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 16'hE803, 8'hFB, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h03, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 1, 16'hE80A, 8'h00, 1, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 16'hE80A, 8'h00, 0, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 1, 16'hE7FF, 8'h00, 1, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 16'hE7FF, 8'h00, 0, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h0C, 0, 16'h0000, 8'h00, 0, 8'hFB, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h0A, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h13, 0, 16'h0000, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 8'hFB, 1, 0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      k.cpu_strobe = tbl[i].stb; k.pia1_enabled_in = tbl[i].pe;
      k.bus_addr = tbl[i].ba; k.bus_rw_b = tbl[i].rw; k.bus_data_in = tbl[i].bd;
      host(tbl[i].req, tbl[i].pa, tbl[i].pd);
      cycle();
      chk($sformatf("vec%0d_ack", i),  16'(k.pi_wr_ack),    16'(tbl[i].ack));
      chk($sformatf("vec%0d_kout", i), 16'(k.kbd_data_out), 16'(tbl[i].kout));
      chk($sformatf("vec%0d_ken", i),  16'(k.kbd_enable),   16'(tbl[i].ken));
      chk($sformatf("vec%0d_lvl", i),  16'(k.fifo_level),   16'(tbl[i].lvl));
    end

    // Host writes under continuous CPU strobes: buffered, then drained in order.
    cpu(1'b1, 2'd1, 1'b1, 8'h00);
    host(1'b1, 16'hE800, 8'h7F); cycle();
    chk("conf_ack0", 16'(k.pi_wr_ack), 16'd1); chk("conf_lvl0", 16'(k.fifo_level), 16'd1);
    host(1'b0, 16'hE800, 8'h7F); cycle();
    chk("conf_lvl1", 16'(k.fifo_level), 16'd1);
    host(1'b1, 16'hE801, 8'hBF); cycle();
    chk("conf_ack2", 16'(k.pi_wr_ack), 16'd1); chk("conf_lvl2", 16'(k.fifo_level), 16'd2);
    host(1'b0, 16'hE801, 8'hBF); cycle();
    chk("conf_lvl3", 16'(k.fifo_level), 16'd2);
    host(1'b1, 16'hE802, 8'h00);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("conf_full_noack", 16'(k.pi_wr_ack), 16'd0);
      chk("conf_full_lvl", 16'(k.fifo_level), 16'd2);
    end
    host(1'b0, 16'h0000, 8'h00); cpu(1'b0, 2'd0, 1'b1, 8'h00); cycle();
    chk("conf_drain1", 16'(k.fifo_level), 16'd1);
    read_row("conf_row1_pending", 8'h01, 8'hFF, 1'b0);
    read_row("conf_row0", 8'h00, 8'h7F, 1'b1);
    cycle();
    chk("conf_drain2", 16'(k.fifo_level), 16'd0);
    read_row("conf_row1", 8'h01, 8'hBF, 1'b1);

    // Request held for ten cycles is accepted exactly once.
    cpu(1'b0, 2'd0, 1'b1, 8'h00);
    host(1'b1, 16'hE805, 8'hDF);
    acks = 0; maxl = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      acks += int'(k.pi_wr_ack);
      if (int'(k.fifo_level) > maxl) maxl = int'(k.fifo_level);
    end
    chk("held_acks", 16'(acks), 16'd1);
    chk("held_maxlvl", 16'(maxl), 16'd1);
    host(1'b0, 16'h0000, 8'h00); cycle();
    chk("held_lvl", 16'(k.fifo_level), 16'd0);
    read_row("held_row5", 8'h05, 8'hDF, 1'b1);

    // Reset with a full FIFO and a request in flight.
    cpu(1'b1, 2'd1, 1'b1, 8'h00);
    host(1'b1, 16'hE806, 8'h00); cycle();
    host(1'b0, 16'hE806, 8'h00); cycle();
    host(1'b1, 16'hE807, 8'h00); cycle();
    host(1'b0, 16'hE807, 8'h00);
    cpu(1'b1, 2'd0, 1'b0, 8'h03); cycle();
    cpu(1'b1, 2'd2, 1'b1, 8'h00); cycle();
    chk("rst_pre_lvl", 16'(k.fifo_level), 16'd2);
    chk("rst_pre_ken", 16'(k.kbd_enable), 16'd1);
    reset = 1'b1; cpu(1'b0, 2'd0, 1'b1, 8'h00); host(1'b1, 16'hE808, 8'h00);
    cycle(); cycle();
    chk("rst_lvl", 16'(k.fifo_level), 16'd0);
    chk("rst_kout", 16'(k.kbd_data_out), 16'h00FF);
    chk("rst_ken", 16'(k.kbd_enable), 16'd0);
    chk("rst_ack", 16'(k.pi_wr_ack), 16'd0);
    reset = 1'b0; host(1'b0, 16'h0000, 8'h00); cycle();
    read_row("rst_row3", 8'h03, 8'hFF, 1'b0);
    read_row("rst_row6", 8'h06, 8'hFF, 1'b0);

    // Random traffic against the reference model.
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    just_acked = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      k.cpu_strobe = ($urandom_range(0, 9) < 4);
      k.pia1_enabled_in = ($urandom_range(0, 7) != 0);
      k.bus_addr = 2'($urandom_range(0, 3));
      k.bus_rw_b = 1'($urandom_range(0, 1));
      k.bus_data_in = 8'($urandom);
      if (!k.pi_wr_req && !just_acked && $urandom_range(0, 3) == 0) begin
        host(1'b1, BASE + 16'($urandom_range(0, 12)) - 16'd1, 8'($urandom));
      end
      cycle();
      just_acked = k.pi_wr_ack;
      if (k.pi_wr_ack) k.pi_wr_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
